gol_sequencer: RTL and testbench
================================

Name: gol_sequencer

Overview:
- Controller for a ROWS x COLS Game of Life cell array.
- Loads the initial pattern serially and broadcasts it through the array's initialize/initialState inputs.
- Advances generations on command (single-step or free-run) by pulsing the array's advance enable, and counts generations.
- Halts on a generation limit, extinction (all cells dead) or still life (board unchanged), and reports why.

Parameters:
- ROWS, 8, board rows.
- COLS, 8, board columns; N = ROWS*COLS.
- GEN_W, 16, width of the generation counter and limit.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst_n  input  1  synchronous active-low reset.
- load_valid  input  1  serial pattern bit valid.
- load_bit  input  1  pattern bit, row-major, cell 0 first.
- load_ready  output  1  sequencer accepts a pattern bit this cycle.
- start  input  1  pulse; begins free-run from READY.
- step  input  1  pulse; advances exactly one generation from READY.
- stop  input  1  pulse; requests halt during free-run.
- max_gens  input  GEN_W  generation limit; 0 = unlimited.
- board_state  input  N  current cell outputs from the array.
- cell_initialize  output  1  drives every cell's initialize.
- cell_init_state  output  N  per-cell initialState.
- cell_advance  output  1  enable; the array updates at the posedge ending a cycle where this is 1.
- generation  output  GEN_W  generations completed since the last load.
- busy  output  1  high in LOAD, INIT, ADV, CHK.
- done  output  1  high in HALT.
- halt_reason  output  2  0 none, 1 limit, 2 extinct, 3 still life or stop.
- halt_stopped  output  1  qualifies reason 3: 1 = user stop, 0 = still life.

Behaviour:
- Reset (rst_n=0 at posedge) puts the FSM in IDLE and clears the shift register and all outputs: load_ready=0, cell_initialize=0, cell_init_state=0, cell_advance=0, generation=0, busy=0, done=0, halt_reason=0, halt_stopped=0. Reset mid-run aborts immediately; no further cell_advance is issued.
- IDLE: load_ready=1. A beat (load_valid & load_ready) shifts load_bit into the shift register at index 0, clears generation, halt_reason and halt_stopped, and moves to LOAD.
- LOAD: load_ready=1. Each beat fills the next index. The beat that fills index N-1 moves to INIT, and load_ready drops the following cycle. Gaps in load_valid are allowed.
- INIT: exactly one cycle. cell_initialize=1, cell_init_state = shift register. Then READY.
- READY: idle with the pattern loaded.
  - start moves to ADV with run_mode=1.
  - step moves to ADV with run_mode=0.
  - If start and step are both high, start wins.
  - load_valid in READY begins a new load (same actions as IDLE).
- ADV: one cycle. cell_advance=1. Snapshot board_state into prev. Go to CHK.
- CHK: one cycle; board_state now shows the new generation. generation increments by 1, saturating at all-ones. Halt checks, in priority order:
  - limit (max_gens != 0 and the incremented value == max_gens) gives reason 1;
  - board_state == 0 gives reason 2;
  - board_state == prev gives reason 3, halt_stopped=0;
  - pending stop gives reason 3, halt_stopped=1.
- CHK exit: on any halt, go to HALT. Otherwise go to ADV if run_mode=1, or READY if run_mode=0.
- Free-run throughput: one generation every 2 cycles.
- stop: a pulse in any cycle of ADV or CHK is latched and acted on at the next CHK. Ignored in other states.
- HALT: done=1; halt_reason and halt_stopped hold.
  - step or start resumes (step: one generation; start: free-run) with generation kept. If both are high, start wins. The stop latch and halt_reason clear on entry to ADV.
  - A load beat starts a new load.
  - A board that is already all-zero halts again after one generation with reason 2. A board that is already still halts again with reason 3.
- Equality and zero checks are purely combinational on N bits.
- cell_advance is never asserted in the same cycle as cell_initialize.

Test Plan:
- Reset, then load 64 bits of a blinker (cells 9,10,11) -> load_ready high for 64 beats; then exactly one cycle of cell_initialize=1 with cell_init_state bits 9,10,11 set; then READY; generation=0, busy=0.
- From READY pulse step twice with the blinker -> cell_advance pulses twice total; generation=2; FSM back in READY each time; done=0.
- Blinker with max_gens=5 and start -> 5 cell_advance pulses at 2-cycle spacing; done=1; halt_reason=1; generation=5.
- Block (still life) pattern, start -> halt after 1 generation; halt_reason=3, halt_stopped=0. Single lone cell, start -> halt_reason=2 after 1 generation.
- Glider, max_gens=0, start, stop pulsed during generation 7's ADV -> halt at generation 7's CHK; halt_reason=3, halt_stopped=1; then step -> generation=8.
- rst_n=0 during free-run, mid-ADV -> next cycle all outputs zero, FSM IDLE, no further cell_advance; load_valid during LOAD gaps and start/step held high simultaneously also covered.

Source files
------------

// File: rtl/gol_sequencer.sv
// Sequencer for a ROWS x COLS Game of Life array: serial pattern load, broadcast
// initialisation, single-step or free-run generation advance, and halt detection.
module gol_sequencer #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  input  logic                   load_bit,
  output logic                   load_ready,
  input  logic                   start,
  input  logic                   step,
  input  logic                   stop,
  input  logic [GEN_W-1:0]       max_gens,
  input  logic [ROWS*COLS-1:0]   board_state,
  output logic                   cell_initialize,
  output logic [ROWS*COLS-1:0]   cell_init_state,
  output logic                   cell_advance,
  output logic [GEN_W-1:0]       generation,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             halt_reason,
  output logic                   halt_stopped
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    StIdle, StLoad, StInit, StReady, StAdv, StChk, StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      sreg_q, sreg_d;
  logic [N-1:0]      prev_q, prev_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [GEN_W-1:0]  gen_q, gen_d, gen_inc;
  logic [1:0]        reason_q, reason_d;
  logic              stopped_q, stopped_d;
  logic              run_q, run_d;
  logic              stop_q, stop_d;
  logic              load_ready_q;
  logic              beat;

  assign beat    = load_valid & load_ready_q;
  assign gen_inc = (&gen_q) ? gen_q : gen_q + GEN_W'(1);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    prev_d    = prev_q;
    idx_d     = idx_q;
    gen_d     = gen_q;
    reason_d  = reason_q;
    stopped_d = stopped_q;
    run_d     = run_q;
    stop_d    = stop_q;

    unique case (state_q)
      StIdle, StReady, StHalt: begin
        if (beat) begin
          state_d   = StLoad;
          sreg_d    = '0;
          sreg_d[0] = load_bit;
          idx_d     = IdxW'(1);
          gen_d     = '0;
          reason_d  = 2'd0;
          stopped_d = 1'b0;
        end else if (state_q != StIdle && (start || step)) begin
          // start wins over step; stale stop requests never carry into a new run
          state_d   = StAdv;
          run_d     = start;
          stop_d    = 1'b0;
          reason_d  = 2'd0;
          stopped_d = 1'b0;
        end
      end
      StLoad: begin
        if (beat) begin
          sreg_d[idx_q] = load_bit;
          if (idx_q == IdxW'(N - 1)) state_d = StInit;
          else                       idx_d   = idx_q + IdxW'(1);
        end
      end
      StInit: state_d = StReady;
      StAdv: begin
        prev_d  = board_state;
        state_d = StChk;
        if (stop) stop_d = 1'b1;
      end
      StChk: begin
        gen_d = gen_inc;
        if (stop) stop_d = 1'b1;
        state_d = run_q ? StAdv : StReady;
        if (max_gens != '0 && gen_inc == max_gens) begin
          reason_d = 2'd1;
          state_d  = StHalt;
        end else if (board_state == '0) begin
          reason_d = 2'd2;
          state_d  = StHalt;
        end else if (board_state == prev_q) begin
          reason_d  = 2'd3;
          stopped_d = 1'b0;
          state_d   = StHalt;
        end else if (stop_q) begin
          reason_d  = 2'd3;
          stopped_d = 1'b1;
          state_d   = StHalt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      prev_q       <= '0;
      idx_q        <= '0;
      gen_q        <= '0;
      reason_q     <= 2'd0;
      stopped_q    <= 1'b0;
      run_q        <= 1'b0;
      stop_q       <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      prev_q       <= prev_d;
      idx_q        <= idx_d;
      gen_q        <= gen_d;
      reason_q     <= reason_d;
      stopped_q    <= stopped_d;
      run_q        <= run_d;
      stop_q       <= stop_d;
      // Registered so it stays low for the first cycle out of reset
      load_ready_q <= state_d inside {StIdle, StLoad, StReady, StHalt};
    end
  end

  assign load_ready      = load_ready_q;
  assign cell_initialize = (state_q == StInit);
  assign cell_init_state = (state_q == StInit) ? sreg_q : '0;
  assign cell_advance    = (state_q == StAdv);
  assign busy            = state_q inside {StLoad, StInit, StAdv, StChk};
  assign done            = (state_q == StHalt);
  assign generation      = gen_q;
  assign halt_reason     = reason_q;
  assign halt_stopped    = stopped_q;

endmodule

// File: tb/tb_gol_sequencer.sv
// Bench for gol_sequencer: a behavioural cell array, a vector table of load/run
// scenarios checked through a scoreboard, and hand sequences for stop and reset.
module tb_gol_sequencer;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 16;
  localparam int N     = ROWS * COLS;

  localparam logic [N-1:0] BLINKER = 64'h0000_0000_0000_0E00;
  localparam logic [N-1:0] BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [N-1:0] LONE    = 64'h0000_0000_0800_0000;
  localparam logic [N-1:0] GLIDER  = 64'h0000_0000_0007_0402;

  logic clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0, load_bit = 1'b0;
  logic start = 1'b0, step = 1'b0, stop = 1'b0;
  logic [GEN_W-1:0] max_gens = '0;
  logic [N-1:0]     board_state;
  logic             load_ready, cell_initialize, cell_advance, busy, done, halt_stopped;
  logic [N-1:0]     cell_init_state;
  logic [GEN_W-1:0] generation;
  logic [1:0]       halt_reason;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gol_sequencer #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_bit(load_bit),
    .load_ready(load_ready), .start(start), .step(step), .stop(stop), .max_gens(max_gens),
    .board_state(board_state), .cell_initialize(cell_initialize),
    .cell_init_state(cell_init_state), .cell_advance(cell_advance), .generation(generation),
    .busy(busy), .done(done), .halt_reason(halt_reason), .halt_stopped(halt_stopped)
  );

  // Bounded board: cells outside the array count as dead
  function automatic logic [N-1:0] life(input logic [N-1:0] b);
    logic [N-1:0] nb;
    int cnt;
    nb = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                c + dc >= 0 && c + dc < COLS)
              cnt += int'(b[(r + dr) * COLS + c + dc]);
        nb[r * COLS + c] = (cnt == 3) || (b[r * COLS + c] && cnt == 2);
      end
    end
    return nb;
  endfunction

  logic [N-1:0] board_q = '0;
  assign board_state = board_q;
  always @(posedge clk) begin
    if (cell_initialize)   board_q <= cell_init_state;
    else if (cell_advance) board_q <= life(board_q);
  end

  int cyc = 0;
  int overlap = 0;
  int adv_times[$];
  always @(negedge clk) begin
    cyc++;
    if (cell_advance) adv_times.push_back(cyc);
    if (cell_advance && cell_initialize) overlap++;
  end

  typedef struct {
    logic [GEN_W-1:0] gen;
    logic             dn;
    logic [1:0]       reason;
    logic             stp;
    int               adv;
  } exp_t;

  typedef struct {
    logic             reload;
    logic [N-1:0]     pat;
    logic             gaps;
    logic [GEN_W-1:0] maxg;
    int               mode;   // 0 step, 1 start, 2 start and step together
    int               steps;
    exp_t             e;
  } vec_t;

  exp_t sb[$];

  function automatic vec_t mk(logic reload, logic [N-1:0] pat, logic gaps, int maxg, int mode,
                              int steps, int gen, logic dn, int reason, logic stp, int adv);
    vec_t v;
    v.reload = reload; v.pat = pat; v.gaps = gaps; v.maxg = GEN_W'(maxg);
    v.mode = mode; v.steps = steps;
    v.e.gen = GEN_W'(gen); v.e.dn = dn; v.e.reason = 2'(reason); v.e.stp = stp; v.e.adv = adv;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_not_busy(input string name);
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    check({name, " timeout"}, 64'(busy), 64'(0));
  endtask

  task automatic pulse(input logic s_start, input logic s_step);
    @(negedge clk);
    start = s_start; step = s_step;
    @(negedge clk);
    start = 1'b0; step = 1'b0;
  endtask

  task automatic load_pattern(input logic [N-1:0] pat, input logic gaps, input int id);
    int rdy;
    rdy = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (gaps && (i % 5) == 2) begin
        load_valid = 1'b0;
        @(negedge clk);
      end
      rdy += int'(load_ready);
      load_valid = 1'b1;
      load_bit   = pat[i];
    end
    @(negedge clk);
    load_valid = 1'b0; load_bit = 1'b0;
    check($sformatf("v%0d ready beats", id), 64'(rdy), 64'(N));
    check($sformatf("v%0d init pulse", id), {62'd0, cell_initialize, load_ready}, 64'd2);
    check($sformatf("v%0d init state", id), 64'(cell_init_state), 64'(pat));
    @(negedge clk);
    check($sformatf("v%0d ready state", id),
          {44'd0, cell_initialize, cell_advance, busy, done, generation}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    int ok;
    max_gens = v.maxg;
    if (v.reload) load_pattern(v.pat, v.gaps, id);
    sb.push_back(v.e);
    adv_times.delete();
    for (int s = 0; s < v.steps; s++) begin
      pulse(v.mode != 0, v.mode != 1);
      wait_not_busy($sformatf("v%0d", id));
    end
    e = sb.pop_front();
    check($sformatf("v%0d generation", id), 64'(generation), 64'(e.gen));
    check($sformatf("v%0d done/reason/stopped", id), {60'd0, done, halt_reason, halt_stopped},
          {60'd0, e.dn, e.reason, e.stp});
    check($sformatf("v%0d advances", id), 64'(adv_times.size()), 64'(e.adv));
    if (v.mode != 0) begin
      ok = 1;
      for (int k = 1; k < adv_times.size(); k++)
        if (adv_times[k] - adv_times[k-1] != 2) ok = 0;
      check($sformatf("v%0d advance spacing", id), 64'(ok), 64'(1));
    end
  endtask

  initial begin
    vec_t vt[8];
    int hit;
    int n0;
    vt[0] = mk(1, BLINKER, 0, 0, 0, 2, 2, 0, 0, 0, 2);
    vt[1] = mk(1, BLINKER, 1, 5, 1, 1, 5, 1, 1, 0, 5);
    vt[2] = mk(1, BLOCK,   0, 0, 1, 1, 1, 1, 3, 0, 1);
    vt[3] = mk(0, BLOCK,   0, 0, 0, 1, 2, 1, 3, 0, 1);
    vt[4] = mk(1, LONE,    0, 0, 1, 1, 1, 1, 2, 0, 1);
    vt[5] = mk(0, LONE,    0, 0, 1, 1, 2, 1, 2, 0, 1);
    vt[6] = mk(1, BLINKER, 0, 3, 2, 1, 3, 1, 1, 0, 3);
    vt[7] = mk(1, GLIDER,  1, 4, 1, 1, 4, 1, 1, 0, 4);

    repeat (2) @(negedge clk);
    check("reset outputs", {43'd0, load_ready, cell_initialize, cell_advance, generation, busy,
                            done, halt_reason, halt_stopped}, 64'd0);
    check("reset init state", 64'(cell_init_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle load_ready", {62'd0, load_ready, busy}, 64'd2);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Stop during the ADV that produces generation 7
    load_pattern(GLIDER, 0, 90);
    max_gens = '0;
    pulse(1'b1, 1'b0);
    hit = 0;
    for (int k = 0; k < 100 && hit == 0; k++) begin
      if (cell_advance && generation == GEN_W'(6)) begin
        stop = 1'b1;
        hit = 1;
      end
      @(negedge clk);
    end
    stop = 1'b0;
    check("stop window found", 64'(hit), 64'(1));
    wait_not_busy("stop run");
    check("stop generation", 64'(generation), 64'(7));
    check("stop halt", {61'd0, done, halt_reason, halt_stopped}, {61'd0, 1'b1, 2'd3, 1'b1});
    pulse(1'b0, 1'b1);
    wait_not_busy("resume step");
    check("resume generation", 64'(generation), 64'(8));
    check("resume cleared", {61'd0, done, halt_reason}, 64'd0);
    // stop outside ADV/CHK must be ignored
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    pulse(1'b0, 1'b1);
    wait_not_busy("ignored stop");
    check("ignored stop", {44'd0, done, halt_reason, generation}, 64'(9));

    // Reset in the middle of a free run
    load_pattern(BLINKER, 0, 91);
    pulse(1'b1, 1'b0);
    hit = 0;
    for (int k = 0; k < 100 && hit == 0; k++) begin
      if (cell_advance && generation == GEN_W'(2)) begin
        rst_n = 1'b0;
        hit = 1;
      end
      @(negedge clk);
    end
    check("reset window found", 64'(hit), 64'(1));
    check("midrun reset outputs", {43'd0, load_ready, cell_initialize, cell_advance, generation,
                                   busy, done, halt_reason, halt_stopped}, 64'd0);
    rst_n = 1'b1;
    n0 = adv_times.size();
    repeat (10) @(negedge clk);
    check("no advance after reset", 64'(adv_times.size()), 64'(n0));
    check("idle after reset", {61'd0, load_ready, busy, done}, 64'd4);
    check("init/advance overlap", 64'(overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
